// File: rtl/spi_device.sv
`timescale 1ns/1ps
// spi_device: SPI mode-0 slave that decodes DW-bit frames {wr, addr, data}
// into single-cycle register accesses on the clk domain. The register data
// returned for a read is shifted out on MISO during the data phase.
//
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   spi_sck/csn/mosi    SPI inputs, asynchronous to clk (synchronized here)
//   spi_miso            SPI read data, MSB first, 0 outside a read data phase
//   reg_req/wr/addr     one-cycle register access strobe with direction/address
//   reg_wdata           write data, valid with reg_req when reg_wr=1
//   reg_rdata           read data, sampled exactly one clk after a read reg_req
//   frame_done/err      one-cycle pulse at csn rise: full frame / wrong length
module spi_device #(
  parameter int DW = 38,
  parameter int TX = 22,
  parameter int RX = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          spi_sck,
  input  logic          spi_csn,
  input  logic          spi_mosi,
  output logic          spi_miso,
  output logic          reg_req,
  output logic          reg_wr,
  output logic [TX-2:0] reg_addr,
  output logic [RX-1:0] reg_wdata,
  input  logic [RX-1:0] reg_rdata,
  output logic          frame_done,
  output logic          frame_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_DONE
  } state_t;

  localparam logic [7:0] C_TX_M1 = 8'(TX - 1);
  localparam logic [7:0] C_DW_M1 = 8'(DW - 1);
  localparam logic [7:0] C_DW    = 8'(DW);
  localparam logic [7:0] C_SAT   = 8'(DW + 1);

  // Two-flop synchronizers plus one extra stage on sck/csn for edge detection.
  logic r_sck_s1, r_sck_s2, r_sck_d;
  logic r_csn_s1, r_csn_s2, r_csn_d;
  logic r_mosi_s1, r_mosi_s2;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [7:0]    r_cnt;
  // The frame MSB (write flag) is consumed straight from w_shift_nxt on the
  // last rise, so only DW-1 received bits ever need to be stored.
  logic [DW-2:0] r_shift;
  logic [DW-1:0] w_shift_nxt;
  logic [RX-1:0] r_miso_sr;
  logic          r_rd_pend;
  logic          r_rd_frame;

  logic w_sck_rise, w_sck_fall, w_csn_rise, w_csn_fall;
  logic w_sck_ok;
  logic w_rd_req, w_wr_req;

  assign w_sck_rise  =  r_sck_s2 & ~r_sck_d;
  assign w_sck_fall  = ~r_sck_s2 &  r_sck_d;
  assign w_csn_rise  =  r_csn_s2 & ~r_csn_d;
  assign w_csn_fall  = ~r_csn_s2 &  r_csn_d;
  // A rise is only honoured inside an active frame; during a csn rise cycle
  // r_csn_s2 is already high, so the csn edge wins over a coincident sck edge.
  assign w_sck_ok    = w_sck_rise & ~r_csn_s2 & (r_state != S_IDLE);
  assign w_shift_nxt = {r_shift, r_mosi_s2};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rd_req    = 1'b0;
    w_wr_req    = 1'b0;
    if (w_csn_rise) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_csn_fall) w_state_nxt = S_HDR;
        end
        S_HDR: begin
          if (w_sck_ok && (r_cnt == C_TX_M1)) begin
            w_state_nxt = S_DATA;
            w_rd_req    = ~w_shift_nxt[TX-1];
          end
        end
        S_DATA: begin
          if (w_sck_ok && (r_cnt == C_DW_M1)) begin
            w_state_nxt = S_DONE;
            w_wr_req    = w_shift_nxt[DW-1];
          end
        end
        default: begin
          w_state_nxt = r_state;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sck_s1   <= 1'b0;
      r_sck_s2   <= 1'b0;
      r_sck_d    <= 1'b0;
      r_csn_s1   <= 1'b1;
      r_csn_s2   <= 1'b1;
      r_csn_d    <= 1'b1;
      r_mosi_s1  <= 1'b0;
      r_mosi_s2  <= 1'b0;
      r_cnt      <= 8'd0;
      r_shift    <= '0;
      r_miso_sr  <= '0;
      r_rd_pend  <= 1'b0;
      r_rd_frame <= 1'b0;
      spi_miso   <= 1'b0;
      reg_req    <= 1'b0;
      reg_wr     <= 1'b0;
      reg_addr   <= '0;
      reg_wdata  <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      r_sck_s1  <= spi_sck;
      r_sck_s2  <= r_sck_s1;
      r_sck_d   <= r_sck_s2;
      r_csn_s1  <= spi_csn;
      r_csn_s2  <= r_csn_s1;
      r_csn_d   <= r_csn_s2;
      r_mosi_s1 <= spi_mosi;
      r_mosi_s2 <= r_mosi_s1;

      reg_req    <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      // Register slave returns read data on the clk after the strobe.
      r_rd_pend  <= reg_req & ~reg_wr;

      if (w_csn_fall) begin
        r_cnt      <= 8'd0;
        r_rd_frame <= 1'b0;
      end else if (w_sck_ok) begin
        if (r_cnt != C_SAT) r_cnt <= r_cnt + 8'd1;
        if (r_cnt < C_DW)   r_shift <= w_shift_nxt[DW-2:0];
      end

      if (w_rd_req) begin
        reg_req    <= 1'b1;
        reg_wr     <= 1'b0;
        reg_addr   <= w_shift_nxt[TX-2:0];
        r_rd_frame <= 1'b1;
      end
      if (w_wr_req) begin
        reg_req   <= 1'b1;
        reg_wr    <= 1'b1;
        reg_addr  <= w_shift_nxt[DW-2:RX];
        reg_wdata <= w_shift_nxt[RX-1:0];
      end

      if (w_csn_rise) begin
        spi_miso   <= 1'b0;
        r_rd_frame <= 1'b0;
        if (r_cnt == C_DW) frame_done <= 1'b1;
        else               frame_err  <= 1'b1;
      end else if (r_rd_pend) begin
        r_miso_sr <= reg_rdata;
      end else if (w_sck_fall && (r_state == S_DATA) && r_rd_frame) begin
        spi_miso  <= r_miso_sr[RX-1];
        r_miso_sr <= {r_miso_sr[RX-2:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_spi_device.sv
`timescale 1ns/1ps
// tb_spi_device: table-driven directed frames against spi_device, plus
// hand-written sequences for mid-frame reset and back-to-back frames.
module tb_spi_device;
  localparam int DW = 38;
  localparam int TX = 22;
  localparam int RX = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          spi_sck = 1'b0;
  logic          spi_csn = 1'b1;
  logic          spi_mosi = 1'b0;
  logic          spi_miso;
  logic          reg_req;
  logic          reg_wr;
  logic [TX-2:0] reg_addr;
  logic [RX-1:0] reg_wdata;
  logic [RX-1:0] reg_rdata;
  logic          frame_done;
  logic          frame_err;

  // clk = 100 MHz; host SCK half period 40 ns gives clk = 8x SCK.
  always #5 clk = ~clk;

  spi_device #(.DW(DW), .TX(TX), .RX(RX)) dut (
    .clk(clk), .rst(rst),
    .spi_sck(spi_sck), .spi_csn(spi_csn), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso),
    .reg_req(reg_req), .reg_wr(reg_wr), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
    .frame_done(frame_done), .frame_err(frame_err)
  );

  // Register slave: data valid only in the cycle right after a read strobe.
  logic [RX-1:0] rd_value = '0;
  always @(posedge clk) begin
    reg_rdata <= (reg_req && !reg_wr) ? rd_value : 16'hDEAD;
  end

  // Monitor, sampled on the falling clk edge.
  int            host_bit = 0;
  int            req_cnt = 0, done_cnt = 0, err_cnt = 0, miso_hi = 0;
  logic          cap_wr = 1'b0;
  logic [TX-2:0] cap_addr = '0;
  logic [RX-1:0] cap_wdata = '0;
  int            cap_bit = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (reg_req) begin
        req_cnt   <= req_cnt + 1;
        cap_wr    <= reg_wr;
        cap_addr  <= reg_addr;
        cap_wdata <= reg_wdata;
        cap_bit   <= host_bit;
      end
      if (frame_done) done_cnt <= done_cnt + 1;
      if (frame_err)  err_cnt  <= err_cnt + 1;
      if (spi_miso)   miso_hi  <= miso_hi + 1;
    end
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Clocks n bits MSB first; bits past DW are sent as 1. MISO is captured
  // at each rise of the data phase.
  task automatic send_bits(input int n, input logic [DW-1:0] w, output logic [RX-1:0] cap);
    cap = '0;
    for (int i = 0; i < n; i++) begin
      spi_mosi = (i < DW) ? w[DW-1-i] : 1'b1;
      #40;
      spi_sck = 1'b1;
      host_bit++;
      if (i >= TX && i < DW) cap[DW-1-i] = spi_miso;
      #40;
      spi_sck = 1'b0;
    end
    spi_mosi = 1'b0;
  endtask

  task automatic frame(input int n, input logic [DW-1:0] w, output logic [RX-1:0] cap);
    spi_csn  = 1'b0;
    host_bit = 0;
    #40;
    send_bits(n, w, cap);
    #40;
    spi_csn = 1'b1;
  endtask

  typedef struct {
    int            nbits;
    logic [DW-1:0] word;
    logic [RX-1:0] rdata;
    int            exp_req;
    logic          exp_wr;
    logic [TX-2:0] exp_addr;
    logic [RX-1:0] exp_wdata;
    int            exp_bit;
    int            exp_done;
    int            exp_err;
    logic          chk_miso;
    logic [RX-1:0] exp_miso;
    logic          quiet;
  } vec_t;

  task automatic run_vec(input vec_t v, input string tag);
    int r0, d0, e0, m0;
    logic [RX-1:0] cap;
    r0 = req_cnt; d0 = done_cnt; e0 = err_cnt; m0 = miso_hi;
    rd_value = v.rdata;
    frame(v.nbits, v.word, cap);
    repeat (10) @(negedge clk);
    check({tag, " req_count"}, 64'(req_cnt - r0), 64'(v.exp_req));
    if (v.exp_req > 0) begin
      check({tag, " reg_wr"}, 64'(cap_wr), 64'(v.exp_wr));
      check({tag, " reg_addr"}, 64'(cap_addr), 64'(v.exp_addr));
      check({tag, " req_bit"}, 64'(cap_bit), 64'(v.exp_bit));
      if (v.exp_wr) check({tag, " reg_wdata"}, 64'(cap_wdata), 64'(v.exp_wdata));
    end
    check({tag, " frame_done"}, 64'(done_cnt - d0), 64'(v.exp_done));
    check({tag, " frame_err"}, 64'(err_cnt - e0), 64'(v.exp_err));
    if (v.chk_miso) check({tag, " miso_data"}, 64'(cap), 64'(v.exp_miso));
    if (v.quiet) check({tag, " miso_quiet"}, 64'(miso_hi - m0), 64'd0);
    check({tag, " miso_idle"}, 64'(spi_miso), 64'd0);
  endtask

  vec_t tv[9];

  initial begin
    logic [RX-1:0] cap;
    int r0, d0, e0;

    //          nbits word                              rdata    req wr    addr        wdata     bit done err chk   exp_miso  quiet
    tv[0] = '{38, {1'b1, 21'h00A5A, 16'hBEEF}, 16'h0000, 1, 1'b1, 21'h00A5A, 16'hBEEF, 38, 1, 0, 1'b0, 16'h0000, 1'b1};
    tv[1] = '{38, {1'b0, 21'h00123, 16'h0000}, 16'h1234, 1, 1'b0, 21'h00123, 16'h0000, 22, 1, 0, 1'b1, 16'h1234, 1'b0};
    tv[2] = '{10, {1'b1, 21'h00A5A, 16'hBEEF}, 16'h0000, 0, 1'b0, 21'h00000, 16'h0000,  0, 0, 1, 1'b0, 16'h0000, 1'b1};
    tv[3] = '{38, {1'b1, 21'h1FFFFF, 16'h0001}, 16'h0000, 1, 1'b1, 21'h1FFFFF, 16'h0001, 38, 1, 0, 1'b0, 16'h0000, 1'b1};
    tv[4] = '{40, {1'b1, 21'h0F0F0, 16'h5A5A}, 16'h0000, 1, 1'b1, 21'h0F0F0, 16'h5A5A, 38, 0, 1, 1'b0, 16'h0000, 1'b1};
    tv[5] = '{30, {1'b0, 21'h00001, 16'h0000}, 16'hABCD, 1, 1'b0, 21'h00001, 16'h0000, 22, 0, 1, 1'b0, 16'h0000, 1'b0};
    tv[6] = '{37, {1'b1, 21'h12345, 16'hCAFE}, 16'h0000, 0, 1'b0, 21'h00000, 16'h0000,  0, 0, 1, 1'b0, 16'h0000, 1'b1};
    tv[7] = '{40, {1'b0, 21'h1ABCD, 16'h0000}, 16'h8001, 1, 1'b0, 21'h1ABCD, 16'h0000, 22, 0, 1, 1'b1, 16'h8001, 1'b0};
    tv[8] = '{21, {1'b0, 21'h00055, 16'h0000}, 16'hFFFF, 0, 1'b0, 21'h00000, 16'h0000,  0, 0, 1, 1'b0, 16'h0000, 1'b1};

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst reg_req", 64'(reg_req), 64'd0);
    check("rst spi_miso", 64'(spi_miso), 64'd0);
    check("rst reg_addr", 64'(reg_addr), 64'd0);
    check("rst reg_wdata", 64'(reg_wdata), 64'd0);
    check("rst frame_flags", 64'({frame_done, frame_err}), 64'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("post_rst idle", 64'({reg_req, spi_miso, frame_done, frame_err}), 64'd0);

    for (int k = 0; k < 9; k++) begin
      run_vec(tv[k], $sformatf("vec%0d", k));
      repeat (10) @(negedge clk);
    end

    // Reset asserted at bit 30 of a write frame.
    r0 = req_cnt; d0 = done_cnt; e0 = err_cnt;
    spi_csn  = 1'b0;
    host_bit = 0;
    #40;
    send_bits(30, {1'b1, 21'h0ABCD, 16'h1357}, cap);
    #20;
    rst = 1'b1;
    #10;
    spi_csn = 1'b1;
    #1;
    check("midrst reg_addr", 64'(reg_addr), 64'd0);
    check("midrst reg_wdata", 64'(reg_wdata), 64'd0);
    check("midrst reg_wr", 64'(reg_wr), 64'd0);
    check("midrst outs", 64'({reg_req, spi_miso, frame_done, frame_err}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("midrst req_count", 64'(req_cnt - r0), 64'd0);
    check("midrst frame_flags", 64'((done_cnt - d0) + (err_cnt - e0)), 64'd0);
    run_vec(tv[0], "after_rst");
    repeat (10) @(negedge clk);

    // Back-to-back frames with a 2-clk csn-high gap.
    r0 = req_cnt; d0 = done_cnt; e0 = err_cnt;
    frame(38, {1'b1, 21'h00003, 16'h1111}, cap);
    check("b2b first wr", 64'(cap_wr), 64'd1);
    check("b2b first addr", 64'(cap_addr), 64'h3);
    check("b2b first wdata", 64'(cap_wdata), 64'h1111);
    rd_value = 16'h4242;
    #20;
    frame(38, {1'b0, 21'h00004, 16'h0000}, cap);
    repeat (10) @(negedge clk);
    check("b2b req_count", 64'(req_cnt - r0), 64'd2);
    check("b2b frame_done", 64'(done_cnt - d0), 64'd2);
    check("b2b frame_err", 64'(err_cnt - e0), 64'd0);
    check("b2b second wr", 64'(cap_wr), 64'd0);
    check("b2b second addr", 64'(cap_addr), 64'h4);
    check("b2b miso_data", 64'(cap), 64'h4242);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
